dac_sample_feeder: RTL and testbench
====================================

# dac_sample_feeder

Sample buffer and code converter that sits directly upstream of the AD5543 serial DAC driver. It accepts signed two's-complement samples over a valid/ready stream, buffers them in a small FIFO, converts them to the DAC's offset-binary code, and presents a stable parallel word on `dac_data`. It advances to the next sample only when the downstream serializer signals that it has captured the current word. A prefill state machine re-primes the buffer after reset and after every underflow, which keeps the DAC update rate jitter-free.

## Interface
- `DW`, 16: sample and DAC word width.
- `DEPTH`, 8: FIFO depth in samples; must be a power of two and ≥ 2.
- `PREFILL`, 4: FIFO level required to enter RUN; 1 ≤ PREFILL ≤ DEPTH.
- `OFFSET_BIN`, 1: 1 = invert the MSB (two's complement → offset binary); 0 = pass the word through unchanged.
- `UNDERFLOW_MID`, 1: on underflow, 1 = output the zero code; 0 = hold the last word.

Ports:
- `aclk`  in  1: single clock. Everything below is synchronous to its rising edge.
- `areset`  in  1: synchronous, active-high reset.
- `en`  in  1: global enable. When low: no push, no pop, `s_ready` = 0, `load` ignored, state held.
- `s_data`  in  DW: signed input sample.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: the FIFO can accept a sample this cycle.
- `load`  in  1: single-cycle strobe from the serializer, asserted on the cycle it latches `dac_data`.
- `dac_data`  out  DW: registered DAC code, stable between `load` strobes.
- `running`  out  1: high while in RUN.
- `level`  out  $clog2(DEPTH+1): current FIFO occupancy.
- `underflow_cnt`  out  16: saturating count of underflow events.

## Operation
- ZERO code is `{1'b1,{DW-1{1'b0}}}` when OFFSET_BIN=1, and `'0` when OFFSET_BIN=0.
- Conversion: `conv(x)` = `{~x[DW-1], x[DW-2:0]}` when OFFSET_BIN=1, else `x`.
- Push happens when `en && s_valid && s_ready`. `s_ready` = `en && (level != DEPTH)`, derived from the registered level.
- The FIFO uses wrap-around read and write pointers of width $clog2(DEPTH) plus a separate occupancy counter.
- A push and a pop in the same cycle leave `level` unchanged.
- State machine, two states:
  - FILL (reset state):
    - `load` is ignored; nothing is popped and no underflow is counted.
    - `dac_data` holds its current value.
    - Go to RUN on the cycle after `level >= PREFILL` is observed.
  - RUN, on `en && load`:
    - If `level != 0`: pop the head, `dac_data <= conv(head)`.
    - If `level == 0` (underflow): `underflow_cnt` increments, saturating at 16'hFFFF. `dac_data <=` ZERO if UNDERFLOW_MID=1, else holds. The state returns to FILL.
- Push and `load` on the same cycle with the FIFO empty: there is no bypass. It counts as an underflow, and the pushed sample enters the FIFO.
- While the FIFO is full, a `load` pop and the freed slot become visible through `s_ready` on the next cycle.

## Timing
- Reset values:
  - `dac_data` = ZERO
  - `s_ready` = 0 during reset; 1 on the first cycle after reset if `en`
  - `running` = 0, state = FILL
  - `level` = 0, both pointers = 0
  - `underflow_cnt` = 0
- Reset asserted mid-operation clears the FIFO contents logically (pointers and level), returns the state to FILL and sets `dac_data` to ZERO on the next edge.
- Push-to-`level` latency: 1 cycle.
- `load`-to-`dac_data` latency: 1 cycle. The serializer captures the old word on the `load` cycle; the new word is stable from the next edge until the following `load`.
- FILL→RUN: `running` rises 1 cycle after `level` first reaches PREFILL.
- RUN→FILL: `running` falls on the edge that processes the underflow `load`.
- The minimum `load` spacing supported is 1 cycle; the normal spacing is the serializer frame of 24 cycles.
- `underflow_cnt` is cleared only by `areset`.

## Test plan
- **Reset and prefill:** reset, then push 0x0001, 0x0002, 0x0003 with `load` pulsing every 24 cycles → `dac_data` = 0x8000, `running` = 0, `level` = 3, no pops. Push 0x0004 → `running` = 1 one cycle after `level` = 4.
- **Conversion:** in RUN with samples 0x0000, 0x7FFF, 0x8000, 0xFFFF queued, one `load` each → `dac_data` = 0x8000, 0xFFFF, 0x0000, 0x7FFF, each 1 cycle after its `load`. With OFFSET_BIN=0, the same stimulus → the words pass through unchanged.
- **Full backpressure:** hold `s_valid` = 1 with no `load` → `level` = 8, `s_ready` = 0, and no ninth sample is lost or overwritten. One `load` → `s_ready` = 1 the next cycle and the ninth sample is accepted; FIFO order is preserved.
- **Underflow:** drain to empty, then `load` → `underflow_cnt` = 1, `running` = 0, `dac_data` = 0x8000. With UNDERFLOW_MID=0 → `dac_data` holds the last word. Refill to 4 → RUN resumes.
- **Simultaneous events:** empty FIFO in RUN, push and `load` on the same cycle → underflow counted, `level` = 1, state = FILL. Separately, at `level` = 2 with push and pop on the same cycle → `level` stays 2.
- **Enable and reset mid-stream:** drop `en` for 10 cycles while `s_valid` and `load` toggle → no state, level or `dac_data` change, and `s_ready` = 0. Assert `areset` at `level` = 5 in RUN → next edge: `level` = 0, FILL, `dac_data` = 0x8000, `underflow_cnt` = 0.

Source files
------------

// File: rtl/dac_sample_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_feeder_if
// Purpose  : Groups the sample stream (s_data/s_valid/s_ready) and the
//            serializer-facing word handshake (load/dac_data) of the
//            dac_sample_feeder.
// Modports : master - sample producer / serializer side
//            slave  - the feeder itself
// Revision : 1.0 - initial release
// ============================================================================
interface dac_sample_feeder_if #(
    parameter int DW = 16
);
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          load;
    logic [DW-1:0] dac_data;

    modport master (
        output s_data,
        output s_valid,
        output load,
        input  s_ready,
        input  dac_data
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  load,
        output s_ready,
        output dac_data
    );
endinterface
`default_nettype wire

// File: rtl/dac_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_feeder
// Purpose  : Buffers signed samples in a small FIFO, converts them to the
//            DAC code and presents one stable word per serializer load.
//            A FILL/RUN machine re-primes the FIFO after reset and after
//            every underflow so DAC updates stay evenly spaced.
// Ports    : aclk          - clock (rising edge)
//            areset        - synchronous active-high reset
//            en            - global enable; low freezes everything
//            bus (slave)   - s_data/s_valid/s_ready stream in,
//                            load strobe in, dac_data word out
//            running       - high while in RUN
//            level         - FIFO occupancy
//            underflow_cnt - saturating underflow event count
// Revision : 1.0 - initial release
// ============================================================================
module dac_sample_feeder #(
    parameter int DW            = 16,
    parameter int DEPTH         = 8,
    parameter int PREFILL       = 4,
    parameter bit OFFSET_BIN    = 1'b1,
    parameter bit UNDERFLOW_MID = 1'b1
) (
    input  wire logic                       aclk,
    input  wire logic                       areset,
    input  wire logic                       en,
    dac_sample_feeder_if.slave              bus,
    output logic                            running,
    output logic [$clog2(DEPTH+1)-1:0]      level,
    output logic [15:0]                     underflow_cnt
);

    localparam int c_LW = $clog2(DEPTH + 1);
    localparam int c_AW = $clog2(DEPTH);

    localparam logic [c_LW-1:0] c_DEPTH_L   = c_LW'(DEPTH);
    localparam logic [c_LW-1:0] c_PREFILL_L = c_LW'(PREFILL);
    localparam logic [DW-1:0]   c_ZERO      = OFFSET_BIN ? {1'b1, {(DW-1){1'b0}}} : '0;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("DEPTH must be a power of two and at least 2");
        end
        if ((PREFILL < 1) || (PREFILL > DEPTH)) begin : g_bad_prefill
            $error("PREFILL must lie in 1..DEPTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DW-1:0]      r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_LW-1:0]    r_level;
    logic [DW-1:0]      r_dac;
    logic [15:0]        r_ucnt;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_uflow;

    // MSB flip maps two's complement onto offset binary.
    function automatic logic [DW-1:0] f_conv(input logic [DW-1:0] x);
        if (OFFSET_BIN) begin
            return {~x[DW-1], x[DW-2:0]};
        end
        return x;
    endfunction

    // Ready looks only at the registered level, so a pop on a full FIFO
    // frees the slot for the producer one cycle later.
    assign w_ready = en && !areset && (r_level != c_DEPTH_L);
    assign w_push  = w_ready && bus.s_valid;

    // Next-state / pop / underflow decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_uflow     = 1'b0;
        case (r_state)
            S_FILL: begin
                if (en && (r_level >= c_PREFILL_L)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (en && bus.load) begin
                    if (r_level != '0) begin
                        w_pop = 1'b1;
                    end else begin
                        // A push on this same cycle does not bypass:
                        // it lands in the FIFO while the load underflows.
                        w_uflow     = 1'b1;
                        w_state_nxt = S_FILL;
                    end
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage carries no reset; pointers and level define what is valid.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.s_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_dac <= c_ZERO;
        end else if (w_pop) begin
            r_dac <= f_conv(r_mem[r_rd_ptr]);
        end else if (w_uflow && UNDERFLOW_MID) begin
            r_dac <= c_ZERO;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ucnt <= '0;
        end else if (w_uflow && (r_ucnt != 16'hFFFF)) begin
            r_ucnt <= r_ucnt + 16'd1;
        end
    end

    assign bus.s_ready    = w_ready;
    assign bus.dac_data   = r_dac;
    assign running        = (r_state == S_RUN);
    assign level          = r_level;
    assign underflow_cnt  = r_ucnt;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_sample_feeder
// Purpose  : Self-checking bench. Two feeders share one stimulus stream:
//            dut_a uses offset binary with mid-scale on underflow, dut_b
//            passes words through and holds the last word on underflow.
//            A queue-based reference model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_sample_feeder;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic areset;
    logic en;

    dac_sample_feeder_if #(.DW(16)) bus_a ();
    dac_sample_feeder_if #(.DW(16)) bus_b ();

    logic        run_a, run_b;
    logic [3:0]  lvl_a, lvl_b;
    logic [15:0] uc_a, uc_b;

    dac_sample_feeder #(
        .DW(16), .DEPTH(8), .PREFILL(4), .OFFSET_BIN(1'b1), .UNDERFLOW_MID(1'b1)
    ) dut_a (
        .aclk          (aclk),
        .areset        (areset),
        .en            (en),
        .bus           (bus_a),
        .running       (run_a),
        .level         (lvl_a),
        .underflow_cnt (uc_a)
    );

    dac_sample_feeder #(
        .DW(16), .DEPTH(8), .PREFILL(4), .OFFSET_BIN(1'b0), .UNDERFLOW_MID(1'b0)
    ) dut_b (
        .aclk          (aclk),
        .areset        (areset),
        .en            (en),
        .bus           (bus_b),
        .running       (run_b),
        .level         (lvl_b),
        .underflow_cnt (uc_b)
    );

    // Reference model state
    logic [15:0] mq[$];
    bit          m_run;
    int unsigned m_cnt;
    logic [15:0] m_dac_a;
    logic [15:0] m_dac_b;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("level_a",   32'(lvl_a), 32'(mq.size()));
        chk("level_b",   32'(lvl_b), 32'(mq.size()));
        chk("running_a", 32'(run_a), 32'(m_run));
        chk("running_b", 32'(run_b), 32'(m_run));
        chk("ucnt_a",    32'(uc_a),  m_cnt);
        chk("ucnt_b",    32'(uc_b),  m_cnt);
        chk("dac_a",     32'(bus_a.dac_data), 32'(m_dac_a));
        chk("dac_b",     32'(bus_b.dac_data), 32'(m_dac_b));
    endtask

    task automatic drive(input bit e, input bit v, input logic [15:0] d, input bit l);
        en            = e;
        bus_a.s_valid = v;
        bus_b.s_valid = v;
        bus_a.s_data  = d;
        bus_b.s_data  = d;
        bus_a.load    = l;
        bus_b.load    = l;
    endtask

    // One clock of stimulus; reports whether the sample was accepted.
    task automatic cycle(input bit e, input bit v, input logic [15:0] d, input bit l,
                         output bit accepted);
        bit          m_ready;
        logic [15:0] h;
        drive(e, v, d, l);
        #1;
        m_ready = e && (mq.size() != 8);
        chk("s_ready_a", 32'(bus_a.s_ready), 32'(m_ready));
        chk("s_ready_b", 32'(bus_b.s_ready), 32'(m_ready));
        accepted = m_ready && v;
        if (m_run && e && l) begin
            if (mq.size() != 0) begin
                h       = mq.pop_front();
                m_dac_a = h ^ 16'h8000;
                m_dac_b = h;
            end else begin
                if (m_cnt != 32'hFFFF) m_cnt++;
                m_dac_a = 16'h8000;
                m_run   = 1'b0;
            end
        end else if (!m_run && e && (mq.size() >= 4)) begin
            m_run = 1'b1;
        end
        if (accepted) mq.push_back(d);
        @(posedge aclk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        areset = 1'b1;
        #1;
        chk("s_ready_rst", 32'(bus_a.s_ready), 32'd0);
        @(posedge aclk);
        #1;
        mq.delete();
        m_run   = 1'b0;
        m_cnt   = 0;
        m_dac_a = 16'h8000;
        m_dac_b = 16'h0000;
        check_state();
        areset = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [15:0] base);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, base + 16'(i), 1'b0, acc);
    endtask

    task automatic load_n(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1, acc);
    endtask

    logic [15:0] conv_in  [4];
    logic [15:0] conv_exp [4];

    initial begin
        bit          acc;
        logic [15:0] pdata;
        int          thr_v, thr_l;

        areset = 1'b1;
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        conv_in  = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
        conv_exp = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
        @(posedge aclk);
        do_reset();

        // Prefill: three samples, loads every 24 cycles are ignored in FILL
        push_n(3, 16'h0001);
        for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 16'h0, (i % 24) == 0, acc);
        chk("pf_level", 32'(lvl_a), 32'd3);
        chk("pf_run",   32'(run_a), 32'd0);
        chk("pf_dac",   32'(bus_a.dac_data), 32'h8000);
        cycle(1'b1, 1'b1, 16'h0004, 1'b0, acc);
        chk("pf_level4", 32'(lvl_a), 32'd4);
        chk("pf_run_lag", 32'(run_a), 32'd0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
        chk("pf_run_up", 32'(run_a), 32'd1);

        // Conversion
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, conv_in[i], 1'b0, acc);
        load_n(4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b1, acc);
            chk("conv_a", 32'(bus_a.dac_data), 32'(conv_exp[i]));
            chk("conv_b", 32'(bus_b.dac_data), 32'(conv_in[i]));
        end

        // Full backpressure: producer holds data until accepted
        pdata = 16'h0100;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1, pdata, 1'b0, acc);
            if (acc) pdata++;
        end
        chk("full_level", 32'(lvl_a), 32'd8);
        chk("full_rdy",   32'(bus_a.s_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, pdata, i == 0, acc);
            if (acc) pdata++;
        end
        chk("full_ninth", 32'(pdata), 32'h0109);

        // Drain to empty, then underflow
        load_n(8);
        chk("drain_dac_b", 32'(bus_b.dac_data), 32'h0108);
        load_n(1);
        chk("uf_cnt",   32'(uc_a), 32'd1);
        chk("uf_run",   32'(run_a), 32'd0);
        chk("uf_dac_a", 32'(bus_a.dac_data), 32'h8000);
        chk("uf_dac_b", 32'(bus_b.dac_data), 32'h0108);
        push_n(4, 16'h0200);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
        chk("refill_run", 32'(run_a), 32'd1);

        // Simultaneous push and load on an empty FIFO in RUN
        load_n(4);
        cycle(1'b1, 1'b1, 16'h0300, 1'b1, acc);
        chk("sim_cnt",   32'(uc_a), 32'd2);
        chk("sim_level", 32'(lvl_a), 32'd1);
        chk("sim_run",   32'(run_a), 32'd0);
        push_n(3, 16'h0301);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
        load_n(2);
        cycle(1'b1, 1'b1, 16'h0310, 1'b1, acc);
        chk("pushpop_level", 32'(lvl_a), 32'd2);

        // Enable low while inputs toggle
        for (int i = 0; i < 10; i++) cycle(1'b0, i[0], 16'(i), !i[0], acc);

        // Reset at level 5 in RUN
        push_n(3, 16'h0400);
        chk("pre_rst_level", 32'(lvl_a), 32'd5);
        chk("pre_rst_run",   32'(run_a), 32'd1);
        do_reset();
        chk("rst_level", 32'(lvl_a), 32'd0);
        chk("rst_dac",   32'(bus_a.dac_data), 32'h8000);

        // Randomized phases: slow loads, fast loads, starved producer
        for (int i = 0; i < 4000; i++) begin
            case ((i / 400) % 3)
                0:       begin thr_v = 60; thr_l = 5;  end
                1:       begin thr_v = 55; thr_l = 50; end
                default: begin thr_v = 25; thr_l = 85; end
            endcase
            if ($urandom_range(999) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(99) < 92, $urandom_range(99) < thr_v,
                      16'($urandom), $urandom_range(99) < thr_l, acc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
